// File: rtl/audio_player_pkg.sv
// Shared definitions for the audio player read path: RAM latency codes,
// prefetch depth and the address-width helper.
package audio_player_pkg;

    localparam int RD_LAT_HIGH_PERF = 32'sd2;
    localparam int RD_LAT_LOW_LAT   = 32'sd1;
    localparam int PREFETCH_DEPTH   = 32'sd2;

    // Index of the highest set bit (floor of log2), 0 for values <= 1.
    // AW = clogb2(depth-1)+1 then gives exactly log2(depth) address bits.
    function automatic int clogb2(input int value);
        int v;
        int r;
        v = value;
        r = 32'sd0;
        while (v > 32'sd1) begin
            v = v >>> 32'sd1;
            r = r + 32'sd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/audio_prefetch_fifo.sv
// Two-entry synchronous FIFO holding samples fetched ahead of playback.
// Push and pop may coincide (occupancy unchanged); flush empties it.
module audio_prefetch_fifo
    import audio_player_pkg::*;
#(
    parameter int WIDTH = 32
)(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [1:0]       o_occ,
    output logic [WIDTH-1:0] o_head
);

    localparam logic [1:0] OCC_FULL = 2'(PREFETCH_DEPTH);

    logic [WIDTH-1:0] r_mem [PREFETCH_DEPTH];
    logic             r_wr_idx;
    logic             r_rd_idx;
    logic [1:0]       r_occ;
    logic             w_push;
    logic             w_pop;

    // Qualify push/pop against occupancy so over/underflow can never corrupt state.
    always_comb begin
        w_pop  = 1'b0;
        w_push = 1'b0;
        if (i_pop && (r_occ != 2'd0)) begin
            w_pop = 1'b1;
        end else begin
            w_pop = 1'b0;
        end
        if (i_push && ((r_occ != OCC_FULL) || w_pop)) begin
            w_push = 1'b1;
        end else begin
            w_push = 1'b0;
        end
    end

    // Sample storage; written at the tail slot on each accepted push.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < PREFETCH_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push && !i_flush) begin
            r_mem[r_wr_idx] <= i_data;
        end
    end

    // Head/tail indices and occupancy; flush wins over push/pop.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_idx <= 1'b0;
            r_rd_idx <= 1'b0;
            r_occ    <= 2'd0;
        end else if (i_flush) begin
            r_wr_idx <= 1'b0;
            r_rd_idx <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr_idx <= ~r_wr_idx;
            end
            if (w_pop) begin
                r_rd_idx <= ~r_rd_idx;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_occ  = r_occ;
    assign o_head = r_mem[r_rd_idx];

endmodule

// File: rtl/audio_buf_reader.sv
// Read-side controller of the audio sample ring buffer. Fetches words ahead
// into a 2-entry prefetch FIFO using a credit scheme (prefetched + in-flight
// never exceeds 2), presents one sample per sample_tick and flags underruns.
// Optional feature macro: AUDIO_BUF_READER_UNDERRUN_CNT_EN enables the
// saturating 16-bit underrun counter; otherwise underrun_cnt is tied to 0.
module audio_buf_reader
    import audio_player_pkg::*;
#(
    parameter int mem_width        = 32,
    parameter int mem_depth        = 4096,
    parameter int read_latency     = RD_LAT_HIGH_PERF,
    parameter int simulation_delay = 1,
    localparam int AW              = clogb2(mem_depth - 1) + 1
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 sample_tick,
    input  logic [AW:0]          wr_ptr,
    output logic [AW:0]          rd_ptr,
    output logic                 ren_b,
    output logic [AW-1:0]        addr_b,
    input  logic [mem_width-1:0] dout_b,
    output logic [mem_width-1:0] sample_out,
    output logic                 sample_vld,
    output logic                 underrun,
    output logic [15:0]          underrun_cnt
);

    // Parameter sanity; simulation_delay only shapes simulation models.
    generate
        if (((read_latency != RD_LAT_HIGH_PERF) && (read_latency != RD_LAT_LOW_LAT)) ||
            (mem_depth < 4) || ((mem_depth & (mem_depth - 1)) != 0) ||
            (simulation_delay < 0)) begin : g_param_check
            $error("audio_buf_reader: illegal parameter combination");
        end
    endgenerate

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]             r_fetch_ptr;
    logic [AW:0]             r_rd_ptr;
    logic [read_latency-1:0] r_vld_sr;
    logic [mem_width-1:0]    r_sample;
    logic                    r_sample_vld;
    logic                    r_underrun;

    logic [read_latency-1:0] w_sr_next;
    logic [1:0]              w_inflight;
    logic [2:0]              w_used;
    logic [1:0]              w_occ;
    logic [mem_width-1:0]    w_head;
    logic                    w_issue;
    logic                    w_return;
    logic                    w_pop;
    logic                    w_underrun;

    // Count reads in flight inside the RAM pipeline.
    always_comb begin
        w_inflight = 2'd0;
        for (int i = 0; i < read_latency; i++) begin
            w_inflight = w_inflight + {1'b0, r_vld_sr[i]};
        end
        w_used = {1'b0, w_occ} + {1'b0, w_inflight};
    end

    // Fetch issue: playing, ring non-empty for fetch, and a free credit.
    always_comb begin
        w_issue = 1'b0;
        if (!rst && en && (r_fetch_ptr != wr_ptr) && (w_used < 3'd2)) begin
            w_issue = 1'b1;
        end else begin
            w_issue = 1'b0;
        end
    end

    // Return/pop/underrun decisions; a same-cycle return is not visible to the tick.
    always_comb begin
        w_return   = 1'b0;
        w_pop      = 1'b0;
        w_underrun = 1'b0;
        w_sr_next  = r_vld_sr << 32'd1;
        w_sr_next[0] = w_issue;
        if (en) begin
            w_return   = r_vld_sr[read_latency-1];
            w_pop      = sample_tick && (w_occ != 2'd0);
            w_underrun = sample_tick && (w_occ == 2'd0);
        end else begin
            w_return   = 1'b0;
            w_pop      = 1'b0;
            w_underrun = 1'b0;
        end
    end

    // In-flight valid shift register, cleared while playback is disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_sr <= '0;
        end else if (!en) begin
            r_vld_sr <= '0;
        end else begin
            r_vld_sr <= w_sr_next;
        end
    end

    // Fetch pointer: advance on issue, rewind to the consumer pointer on flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_ptr <= '0;
        end else if (!en) begin
            r_fetch_ptr <= r_rd_ptr;
        end else if (w_issue) begin
            r_fetch_ptr <= r_fetch_ptr + PTR_ONE;
        end
    end

    // Consumer pointer and presented sample, updated on a successful tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr     <= '0;
            r_sample     <= '0;
            r_sample_vld <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_sample_vld <= w_pop;
            r_underrun   <= w_underrun;
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
                r_sample <= w_head;
            end
        end
    end

    audio_prefetch_fifo #(
        .WIDTH (mem_width)
    ) u_prefetch (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_flush (~en),
        .i_push  (w_return),
        .i_pop   (w_pop),
        .i_data  (dout_b),
        .o_occ   (w_occ),
        .o_head  (w_head)
    );

`ifdef AUDIO_BUF_READER_UNDERRUN_CNT_EN
    logic        r_en_d;
    logic [15:0] r_underrun_cnt;

    // Delayed enable for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en_d <= 1'b0;
        end else begin
            r_en_d <= en;
        end
    end

    // Saturating underrun counter, cleared when playback (re)starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_underrun_cnt <= 16'd0;
        end else if (en && !r_en_d) begin
            r_underrun_cnt <= 16'd0;
        end else if (r_underrun && (r_underrun_cnt != 16'hFFFF)) begin
            r_underrun_cnt <= r_underrun_cnt + 16'd1;
        end
    end

    assign underrun_cnt = r_underrun_cnt;
`else
    assign underrun_cnt = 16'd0;
`endif

    assign rd_ptr     = r_rd_ptr;
    assign ren_b      = w_issue;
    assign addr_b     = r_fetch_ptr[AW-1:0];
    assign sample_out = r_sample;
    assign sample_vld = r_sample_vld;
    assign underrun   = r_underrun;

endmodule

// File: tb/tb_audio_buf_reader.sv
// Bench for audio_buf_reader: two instances (read latency 1 and 2) on an
// 8-deep ring share stimulus; a queue/timestamp model checks every cycle,
// and directed scenarios pin the model with literal expectations.
module tb_audio_buf_reader;

    localparam int W     = 32;
    localparam int DEPTH = 8;
    localparam int PW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          sample_tick;
    logic [PW-1:0] wr_ptr;

    logic [PW-1:0] rd_ptr_o [2];
    logic          ren_o    [2];
    logic [2:0]    addr_o   [2];
    logic [W-1:0]  dout_o   [2];
    logic [W-1:0]  sample_o [2];
    logic          vld_o    [2];
    logic          und_o    [2];
    logic [15:0]   ucnt_o   [2];

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    audio_buf_reader #(.mem_width(W), .mem_depth(DEPTH), .read_latency(1), .simulation_delay(1)) u_dut_ll (
        .clk(clk), .rst(rst), .en(en), .sample_tick(sample_tick), .wr_ptr(wr_ptr),
        .rd_ptr(rd_ptr_o[0]), .ren_b(ren_o[0]), .addr_b(addr_o[0]), .dout_b(dout_o[0]),
        .sample_out(sample_o[0]), .sample_vld(vld_o[0]), .underrun(und_o[0]), .underrun_cnt(ucnt_o[0]));

    audio_buf_reader #(.mem_width(W), .mem_depth(DEPTH), .read_latency(2), .simulation_delay(1)) u_dut_hp (
        .clk(clk), .rst(rst), .en(en), .sample_tick(sample_tick), .wr_ptr(wr_ptr),
        .rd_ptr(rd_ptr_o[1]), .ren_b(ren_o[1]), .addr_b(addr_o[1]), .dout_b(dout_o[1]),
        .sample_out(sample_o[1]), .sample_vld(vld_o[1]), .underrun(und_o[1]), .underrun_cnt(ucnt_o[1]));

    // Ring RAM contents and the two read pipelines (never reset: stale data stays).
    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] ll_q = '0, hp_q1 = '0, hp_q2 = '0;
    initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    always @(posedge clk) begin
        if (ren_o[0]) ll_q <= mem[addr_o[0]];
        if (ren_o[1]) hp_q1 <= mem[addr_o[1]];
        hp_q2 <= hp_q1;
    end
    assign dout_o[0] = ll_q;
    assign dout_o[1] = hp_q2;

    // Behavioural model: pointers, prefetch queue, pending reads with due cycle.
    int unsigned   cyc = 0;
    logic [PW-1:0] m_fetch [2];
    logic [PW-1:0] m_rd    [2];
    logic [W-1:0]  m_pf    [2][2];
    int            m_pfn   [2];
    logic [W-1:0]  m_pend_d   [2][4];
    int unsigned   m_pend_due [2][4];
    int            m_pendn [2];
    logic [W-1:0]  m_sample [2];
    logic          m_vld [2];
    logic          m_und [2];
    logic [15:0]   m_ucnt [2];
    logic          m_en_prev;
    logic          m_iss;
    logic          m_und_prev;

    function automatic logic model_issue(input int d);
        return !rst && en && (m_fetch[d] != wr_ptr) && ((m_pfn[d] + m_pendn[d]) < 2);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                m_fetch[d] = '0; m_rd[d] = '0; m_pfn[d] = 0; m_pendn[d] = 0;
                m_sample[d] = '0; m_vld[d] = 1'b0; m_und[d] = 1'b0; m_ucnt[d] = 16'd0;
            end
            m_en_prev = 1'b0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                m_iss = model_issue(d);
                m_und_prev = m_und[d];
                m_vld[d] = 1'b0;
                m_und[d] = 1'b0;
                if (!en) begin
                    m_pfn[d] = 0; m_pendn[d] = 0; m_fetch[d] = m_rd[d];
                end else begin
                    if (sample_tick) begin
                        if (m_pfn[d] > 0) begin
                            m_sample[d] = m_pf[d][0]; m_vld[d] = 1'b1; m_rd[d] = m_rd[d] + 4'd1;
                            m_pf[d][0] = m_pf[d][1]; m_pfn[d] = m_pfn[d] - 1;
                        end else begin
                            m_und[d] = 1'b1;
                        end
                    end
                    if (m_pendn[d] > 0 && m_pend_due[d][0] == cyc) begin
                        m_pf[d][m_pfn[d]] = m_pend_d[d][0];
                        m_pfn[d] = m_pfn[d] + 1;
                        for (int k = 0; k < 3; k++) begin
                            m_pend_d[d][k] = m_pend_d[d][k+1];
                            m_pend_due[d][k] = m_pend_due[d][k+1];
                        end
                        m_pendn[d] = m_pendn[d] - 1;
                    end
                    if (m_iss) begin
                        m_pend_d[d][m_pendn[d]] = mem[m_fetch[d][2:0]];
                        m_pend_due[d][m_pendn[d]] = cyc + ((d == 0) ? 1 : 2);
                        m_pendn[d] = m_pendn[d] + 1;
                        m_fetch[d] = m_fetch[d] + 4'd1;
                    end
                end
`ifdef AUDIO_BUF_READER_UNDERRUN_CNT_EN
                if (en && !m_en_prev) m_ucnt[d] = 16'd0;
                else if (m_und_prev && m_ucnt[d] != 16'hFFFF) m_ucnt[d] = m_ucnt[d] + 16'd1;
`endif
            end
            m_en_prev = en;
            cyc++;
        end
    end

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, d, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            chk("rd_ptr", d, 32'(rd_ptr_o[d]), 32'(m_rd[d]));
            chk("ren_b", d, 32'(ren_o[d]), 32'(model_issue(d)));
            chk("addr_b", d, 32'(addr_o[d]), 32'(m_fetch[d][2:0]));
            chk("sample_out", d, sample_o[d], m_sample[d]);
            chk("sample_vld", d, 32'(vld_o[d]), 32'(m_vld[d]));
            chk("underrun", d, 32'(und_o[d]), 32'(m_und[d]));
            chk("underrun_cnt", d, 32'(ucnt_o[d]), 32'(m_ucnt[d]));
        end
    end

    task automatic cyc1();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [W-1:0] v);
        mem[wr_ptr[2:0]] = v;
        wr_ptr = wr_ptr + 4'd1;
    endtask

    task automatic tick();
        sample_tick = 1'b1;
        cyc1();
        sample_tick = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; sample_tick = 1'b0; wr_ptr = '0;
        cyc1();
        cyc1();
        for (int d = 0; d < 2; d++) begin
            chk("rst_rd_ptr", d, 32'(rd_ptr_o[d]), 32'd0);
            chk("rst_sample", d, sample_o[d], 32'd0);
            chk("rst_vld", d, 32'(vld_o[d]), 32'd0);
        end
        rst = 1'b0;
    endtask

    function automatic int used_words();
        int a, b;
        a = int'(4'(wr_ptr - m_rd[0]));
        b = int'(4'(wr_ptr - m_rd[1]));
        return (a > b) ? a : b;
    endfunction

    int tick_mod;

    initial begin
        rst = 1'b1; en = 1'b0; sample_tick = 1'b0; wr_ptr = '0;

        // Basic playback: 4 words, ticks every 16 clk, then an underrun.
        do_reset();
        for (int i = 0; i < 4; i++) write_word(32'hA0 + 32'(i));
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            repeat (16) cyc1();
            tick();
            for (int d = 0; d < 2; d++) begin
                chk("t1_vld", d, 32'(vld_o[d]), 32'd1);
                chk("t1_sample", d, sample_o[d], 32'hA0 + 32'(i));
            end
        end
        repeat (16) cyc1();
        tick();
        for (int d = 0; d < 2; d++) begin
            chk("t1_rd_ptr", d, 32'(rd_ptr_o[d]), 32'd4);
            chk("t1_underrun", d, 32'(und_o[d]), 32'd1);
            chk("t1_hold", d, sample_o[d], 32'hA3);
        end

        // Tick in the cycle the first latency-1 return lands.
        do_reset();
        write_word(32'hB0); write_word(32'hB1);
        en = 1'b1;
        cyc1();
        tick();
        chk("t3_underrun", 0, 32'(und_o[0]), 32'd1);
        chk("t3_vld", 0, 32'(vld_o[0]), 32'd0);
        tick();
        chk("t3_vld2", 0, 32'(vld_o[0]), 32'd1);
        chk("t3_sample", 0, sample_o[0], 32'hB0);

        // Wrap: consume 6, then writer advances 6 -> 10.
        do_reset();
        for (int i = 0; i < 6; i++) write_word(32'hC0 + 32'(i));
        en = 1'b1;
        repeat (16) cyc1();
        for (int i = 0; i < 6; i++) begin tick(); repeat (4) cyc1(); end
        for (int i = 0; i < 4; i++) write_word(32'hD6 + 32'(i));
        repeat (8) cyc1();
        for (int i = 0; i < 4; i++) begin
            tick();
            for (int d = 0; d < 2; d++) chk("t2_sample", d, sample_o[d], 32'hD6 + 32'(i));
            repeat (4) cyc1();
        end
        for (int d = 0; d < 2; d++) chk("t2_rd_ptr", d, 32'(rd_ptr_o[d]), 32'd10);

        // Flush with a full prefetch buffer at rd_ptr=5.
        do_reset();
        for (int i = 0; i < 8; i++) write_word(32'hE0 + 32'(i));
        en = 1'b1;
        repeat (16) cyc1();
        for (int i = 0; i < 5; i++) begin tick(); repeat (4) cyc1(); end
        repeat (12) cyc1();
        en = 1'b0;
        cyc1();
        tick();
        for (int d = 0; d < 2; d++) begin
            chk("t4_vld_off", d, 32'(vld_o[d]), 32'd0);
            chk("t4_und_off", d, 32'(und_o[d]), 32'd0);
            chk("t4_rd_hold", d, 32'(rd_ptr_o[d]), 32'd5);
            chk("t4_sample_hold", d, sample_o[d], 32'hE4);
        end
        en = 1'b1;
        #1;
        chk("t4_ren", 1, 32'(ren_o[1]), 32'd1);
        chk("t4_addr", 1, 32'(addr_o[1]), 32'd5);
        repeat (16) cyc1();
        tick();
        for (int d = 0; d < 2; d++) chk("t4_first", d, sample_o[d], 32'hE5);

        // Asynchronous reset in the middle of fetching.
        en = 1'b0;
        cyc1();
        en = 1'b1;
        cyc1();
        #1;
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("t5_rd_ptr", d, 32'(rd_ptr_o[d]), 32'd0);
            chk("t5_ren", d, 32'(ren_o[d]), 32'd0);
            chk("t5_addr", d, 32'(addr_o[d]), 32'd0);
            chk("t5_sample", d, sample_o[d], 32'd0);
            chk("t5_vld", d, 32'(vld_o[d]), 32'd0);
            chk("t5_und", d, 32'(und_o[d]), 32'd0);
        end
        @(posedge clk);
        #1;
        wr_ptr = '0;
        rst = 1'b0;
        repeat (6) cyc1();
        tick();
        for (int d = 0; d < 2; d++) begin
            chk("t5_no_push_und", d, 32'(und_o[d]), 32'd1);
            chk("t5_no_push_vld", d, 32'(vld_o[d]), 32'd0);
        end

        // Randomized playback with writer flow control and enable toggles.
        do_reset();
        en = 1'b1;
        tick_mod = 4;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) tick_mod = int'($urandom_range(1, 6));
            if ($urandom_range(0, 49) == 0) en = ~en;
            sample_tick = ($urandom_range(0, tick_mod - 1) == 0);
            if (used_words() < DEPTH && $urandom_range(0, 1) == 0) write_word($urandom);
            cyc1();
        end
        sample_tick = 1'b0;
        cyc1();

`ifdef AUDIO_BUF_READER_UNDERRUN_CNT_EN
        // Counter saturation on an empty ring, then clear on enable rise.
        do_reset();
        en = 1'b1;
        sample_tick = 1'b1;
        repeat (70000) cyc1();
        sample_tick = 1'b0;
        cyc1();
        cyc1();
        for (int d = 0; d < 2; d++) chk("cnt_sat", d, 32'(ucnt_o[d]), 32'h0000FFFF);
        en = 1'b0;
        cyc1();
        en = 1'b1;
        cyc1();
        cyc1();
        for (int d = 0; d < 2; d++) chk("cnt_clear", d, 32'(ucnt_o[d]), 32'd0);
`else
        for (int d = 0; d < 2; d++) chk("cnt_tied", d, 32'(ucnt_o[d]), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
